wave_rom_slot_arbiter: RTL and testbench
========================================

# wave_rom_slot_arbiter

Time-slot arbiter that shares the single 8-bit wave sample ROM port between up to eight sample-player channels. It owns the 16-slot horizontal counter that channels use to interleave reads, and registers and muxes each channel's address onto the ROM. It also routes returned bytes back with a per-channel valid strobe. It sits between the sample-player channel instances and the wave ROM, and replaces per-channel decoding of a shared H counter.

## Interface
Parameters:
- `NUM_CH`, 8, number of channels; legal range 1..8.
- `ADDR_W`, 17, ROM byte-address width.
- `ROM_LAT`, 1, ROM read latency in cycles from `O_ROM_RD` to `I_ROM_DATA` valid; legal range 1..4.

Ports:
- `I_CLK` in 1: sole clock; all logic on its rising edge.
- `I_RST` in 1: reset; synchronous, active-high.
- `O_H_CNT` out 4: free-running slot counter, 0..15.
- `I_CH_REQ` in NUM_CH: per-channel read request; level, held until granted.
- `I_CH_ADDR` in NUM_CH*ADDR_W: packed request addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
- `O_CH_GNT` out NUM_CH: one-hot, one-cycle pulse; the address was consumed.
- `O_ROM_RD` out 1: ROM read strobe.
- `O_ROM_ADDR` out ADDR_W: ROM byte address.
- `I_ROM_DATA` in 8: ROM read data.
- `O_RD_DATA` out 8: registered return byte, broadcast to all channels.
- `O_CH_VALID` out NUM_CH: one-hot, one-cycle pulse; `O_RD_DATA` belongs to this channel.

## Operation
- The slot counter increments every cycle and wraps 15→0.
- Owned slots: slot 2k+1 belongs to channel k for k < NUM_CH. Odd slots with k ≥ NUM_CH are idle.
- Spare slots: even slots 0,2,…,14 are allocated round-robin (see Configuration).
- Decision cycle (counter = s): sample `I_CH_REQ` and `I_CH_ADDR`.
  - Owned slot: grant only if the owner's request bit is set; otherwise no read.
  - Spare slot: the winner is the first set request bit at index ≥ `rr_ptr`, searching upward with wrap. After a grant, `rr_ptr` becomes (winner+1) mod NUM_CH. With no requests, `rr_ptr` is unchanged and no read is issued.
  - Owned-slot grants never move `rr_ptr`.
- An owner-tag pipeline of depth ROM_LAT+1 carries {valid, channel} from grant to data return. No skid buffer; a requester that is not ready simply keeps `I_CH_REQ` low.
- A request deasserted before the decision cycle is not serviced. Address changes after the decision cycle do not affect the in-flight read.
- A channel may be granted on consecutive slots (owned + spare) and have two reads in flight. Returns are strictly in issue order.

## Timing
- Decision at cycle t.
- Cycle t+1: `O_ROM_RD`=1, `O_ROM_ADDR`=sampled address, `O_CH_GNT[k]`=1. The requester may present its next address from t+1.
- `I_ROM_DATA` is sampled at t+1+ROM_LAT.
- Cycle t+2+ROM_LAT: `O_RD_DATA` holds that byte and `O_CH_VALID[k]`=1.
- Read-to-return latency is therefore ROM_LAT+1 cycles after `O_ROM_RD`.
- At most one read is issued per cycle, giving peak throughput of one byte per cycle.
- `O_ROM_ADDR` and `O_RD_DATA` hold their last values when no read or valid is active.
- Reset values (in effect the cycle after `I_RST` is sampled high): `O_H_CNT`=0, `O_CH_GNT`=0, `O_ROM_RD`=0, `O_ROM_ADDR`=0, `O_RD_DATA`=0, `O_CH_VALID`=0, `rr_ptr`=0.
- Reset mid-operation flushes the tag pipeline. In-flight returns produce no `O_CH_VALID`.
- After reset release, the first decision is at slot 0.

## Configuration
- `WAVE_ARB_SPARE_EN` defined: even slots are allocated round-robin as described. Each channel gets up to 9 reads per 16-cycle frame, which 16-bit samples need.
- Not defined: even slots are always idle, `rr_ptr` logic is removed, and each channel gets exactly one read per frame on slot 2k+1.

## Test plan
- Single owner (spare disabled): channel 3 requests address 0x00100 continuously; ROM_LAT=1.
  - `O_ROM_RD` occurs only 1 cycle after `O_H_CNT`=7.
  - `O_CH_VALID`=8'h08 occurs 2 cycles after the read, carrying the ROM byte.
  - Exactly 1 grant per 16 cycles.
- Round-robin fairness (spare enabled): channels 0, 2 and 5 request continuously.
  - Spare grants cycle 0→2→5→0.
  - Each channel also receives its owned slot.
  - Over 160 cycles, channels 0/2/5 receive 37/37/36 ±1 grants in total.
- No requesters: `I_CH_REQ`=0 for 32 cycles.
  - `O_ROM_RD`, `O_CH_GNT` and `O_CH_VALID` stay 0.
  - `O_H_CNT` wraps 15→0 twice.
- Latency sweep: ROM_LAT=1..4, ROM model returns addr[7:0].
  - `O_RD_DATA` equals the requested address low byte, ROM_LAT+2 cycles after the decision cycle.
  - The valid bit matches the granted channel.
- Reset mid-flight: assert `I_RST` one cycle after a grant, with ROM_LAT=3.
  - No `O_CH_VALID` pulse follows.
  - All outputs are 0 on the next cycle.
  - `O_H_CNT` restarts at 0.
- Back-to-back same channel: channel 0 requests with slots 0 and 1 both available (spare enabled).
  - Two grants on consecutive cycles.
  - Two valids on consecutive cycles, in address order.

Source files
------------

// File: rtl/wave_rom_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wave_rom_slot_arbiter
// Description : Time-slot arbiter sharing one 8-bit wave ROM read port among
//               up to eight sample-player channels. Owns the 16-slot H
//               counter, registers and muxes the granted channel's address
//               onto the ROM, and routes returned bytes back with a one-hot
//               per-channel valid strobe.
//               Odd slot 2k+1 belongs to channel k. Even slots are spare
//               and are shared round-robin only when WAVE_ARB_SPARE_EN is
//               defined; otherwise they stay idle.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_rom_slot_arbiter #(
    parameter int NUM_CH  = 8,
    parameter int ADDR_W  = 17,
    parameter int ROM_LAT = 1
) (
    input  logic                     I_CLK,
    input  logic                     I_RST,
    output logic [3:0]               O_H_CNT,
    input  logic [NUM_CH-1:0]        I_CH_REQ,
    input  logic [NUM_CH*ADDR_W-1:0] I_CH_ADDR,
    output logic [NUM_CH-1:0]        O_CH_GNT,
    output logic                     O_ROM_RD,
    output logic [ADDR_W-1:0]        O_ROM_ADDR,
    input  logic [7:0]               I_ROM_DATA,
    output logic [7:0]               O_RD_DATA,
    output logic [NUM_CH-1:0]        O_CH_VALID
);

    // Channel indices always fit in 3 bits because NUM_CH never exceeds 8.
    localparam int C_CH_W = 3;

    logic [3:0]                 r_h_cnt;
    logic [7:0]                 w_req8;
    logic                       w_gnt_vld;
    logic [C_CH_W-1:0]          w_gnt_ch;
    logic [ADDR_W-1:0]          w_addr_sel;
    logic [NUM_CH-1:0]          w_gnt_onehot;

    logic                       r_rom_rd;
    logic [ADDR_W-1:0]          r_rom_addr;
    logic [NUM_CH-1:0]          r_gnt;

    logic [ROM_LAT:0]              r_tag_vld;
    logic [ROM_LAT:0][C_CH_W-1:0]  r_tag_ch;
    logic [NUM_CH-1:0]             w_ret_onehot;
    logic [7:0]                    r_rd_data;
    logic [NUM_CH-1:0]             r_ch_valid;

    // Zero-extend requests to 8 so idle odd slots (k >= NUM_CH) read as 0.
    assign w_req8 = 8'(I_CH_REQ);

`ifdef WAVE_ARB_SPARE_EN
    logic [C_CH_W-1:0] r_rr_ptr;
    logic              w_spare_hit;
    logic [C_CH_W-1:0] w_spare_ch;
    logic [3:0]        w_idx;

    // Spare-slot winner: first requester at or above rr_ptr, wrapping.
    always_comb begin
        w_spare_hit = 1'b0;
        w_spare_ch  = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(i);
            if (w_idx >= 4'(NUM_CH)) begin
                w_idx = w_idx - 4'(NUM_CH);
            end
            if (!w_spare_hit && w_req8[w_idx[2:0]]) begin
                w_spare_hit = 1'b1;
                w_spare_ch  = w_idx[2:0];
            end
        end
    end

    // Round-robin pointer moves past the winner on spare-slot grants only.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_rr_ptr <= '0;
        end else if (!r_h_cnt[0] && w_spare_hit) begin
            r_rr_ptr <= (w_spare_ch == C_CH_W'(NUM_CH - 1)) ? '0 : w_spare_ch + 3'd1;
        end
    end
`endif

    // Slot decision: odd slots go to their owner, even slots to the spare winner.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        if (r_h_cnt[0]) begin
            w_gnt_vld = w_req8[r_h_cnt[3:1]];
            w_gnt_ch  = r_h_cnt[3:1];
        end
`ifdef WAVE_ARB_SPARE_EN
        else begin
            w_gnt_vld = w_spare_hit;
            w_gnt_ch  = w_spare_ch;
        end
`endif
    end

    // Select the granted channel's address and build the grant one-hot.
    always_comb begin
        w_addr_sel   = '0;
        w_gnt_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_gnt_ch == C_CH_W'(k)) begin
                w_addr_sel      = I_CH_ADDR[k*ADDR_W +: ADDR_W];
                w_gnt_onehot[k] = w_gnt_vld;
            end
        end
    end

    // Slot counter and ROM request stage; address holds when no read issues.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_h_cnt    <= '0;
            r_rom_rd   <= 1'b0;
            r_rom_addr <= '0;
            r_gnt      <= '0;
        end else begin
            r_h_cnt  <= r_h_cnt + 4'd1;
            r_rom_rd <= w_gnt_vld;
            r_gnt    <= w_gnt_onehot;
            if (w_gnt_vld) begin
                r_rom_addr <= w_addr_sel;
            end
        end
    end

    // Owner-tag pipeline: stage 0 aligns with O_ROM_RD, last stage with ROM data.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_tag_vld <= '0;
            r_tag_ch  <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[ROM_LAT-1:0], w_gnt_vld};
            r_tag_ch  <= {r_tag_ch[ROM_LAT-1:0], w_gnt_ch};
        end
    end

    // Decode the returning tag into a channel one-hot.
    always_comb begin
        w_ret_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_ret_onehot[k] = r_tag_vld[ROM_LAT] && (r_tag_ch[ROM_LAT] == C_CH_W'(k));
        end
    end

    // Return stage: capture the ROM byte only for a tagged read; hold otherwise.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_rd_data  <= '0;
            r_ch_valid <= '0;
        end else begin
            r_ch_valid <= w_ret_onehot;
            if (r_tag_vld[ROM_LAT]) begin
                r_rd_data <= I_ROM_DATA;
            end
        end
    end

    assign O_H_CNT    = r_h_cnt;
    assign O_CH_GNT   = r_gnt;
    assign O_ROM_RD   = r_rom_rd;
    assign O_ROM_ADDR = r_rom_addr;
    assign O_RD_DATA  = r_rd_data;
    assign O_CH_VALID = r_ch_valid;

endmodule
`default_nettype wire

// File: tb/tb_wave_rom_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_rom_slot_arbiter
// Description : Self-checking bench for wave_rom_slot_arbiter. Four DUT
//               instances (ROM_LAT = 1..4) share the same request stimulus;
//               each has its own ROM model returning addr[7:0]. A slot-level
//               reference model predicts grants, reads and returns.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wave_rom_slot_arbiter;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 17;
    localparam int NLAT   = 4;
    localparam int HMAX   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        req;
    logic [ADDR_W-1:0]        addr [NUM_CH];
    logic [NUM_CH*ADDR_W-1:0] addr_p;

    logic [3:0]        h_cnt    [NLAT];
    logic [NUM_CH-1:0] gnt      [NLAT];
    logic              rom_rd   [NLAT];
    logic [ADDR_W-1:0] rom_addr [NLAT];
    logic [7:0]        rd_data  [NLAT];
    logic [NUM_CH-1:0] ch_valid [NLAT];

    // Pack per-channel addresses onto the flat bus.
    always_comb begin
        addr_p = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            addr_p[k*ADDR_W +: ADDR_W] = addr[k];
        end
    end

    generate
        for (genvar gi = 0; gi < NLAT; gi++) begin : g_lat
            logic [7:0] pipe [gi+1];
            // ROM model: addr[7:0] after ROM_LAT cycles, noise when no read.
            always @(posedge clk) begin
                pipe[0] <= rom_rd[gi] ? rom_addr[gi][7:0] : 8'($urandom);
                for (int s = 1; s <= gi; s++) begin
                    pipe[s] <= pipe[s-1];
                end
            end
            wave_rom_slot_arbiter #(
                .NUM_CH  (NUM_CH),
                .ADDR_W  (ADDR_W),
                .ROM_LAT (gi + 1)
            ) u_dut (
                .I_CLK      (clk),
                .I_RST      (rst),
                .O_H_CNT    (h_cnt[gi]),
                .I_CH_REQ   (req),
                .I_CH_ADDR  (addr_p),
                .O_CH_GNT   (gnt[gi]),
                .O_ROM_RD   (rom_rd[gi]),
                .O_ROM_ADDR (rom_addr[gi]),
                .I_ROM_DATA (pipe[gi]),
                .O_RD_DATA  (rd_data[gi]),
                .O_CH_VALID (ch_valid[gi])
            );
        end
    endgenerate

    // Reference model state
    int                errors = 0;
    int                checks = 0;
    int                n      = 0;
    int                slot   = 0;
    int                rr     = 0;
    bit                hv [HMAX];
    int                hc [HMAX];
    logic [ADDR_W-1:0] ha [HMAX];
    logic [ADDR_W-1:0] exp_addr_last;
    logic [7:0]        exp_data_last [NLAT];

    // Observation counters (instance 0)
    int gcnt [NUM_CH];
    int rd_cnt;
    int vld_cnt;
    int wraps;

    task automatic chk(input string tag, input int lat, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s lat=%0d observed=%0h expected=%0h", tag, lat, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NUM_CH; k++) gcnt[k] = 0;
        rd_cnt  = 0;
        vld_cnt = 0;
        wraps   = 0;
    endtask

    // One clock: predict the decision, advance, then compare every instance.
    task automatic step(input logic r);
        bit                dv;
        int                dc;
        int                src;
        logic [ADDR_W-1:0] da;
        logic [NUM_CH-1:0] eg;
        logic [NUM_CH-1:0] ev;
        logic [3:0]        prev_h;
        dv  = 1'b0;
        dc  = 0;
        rst = r;
        if (!r && (slot % 2 == 1) && (slot / 2 < NUM_CH)) begin
            if (req[slot/2]) begin
                dv = 1'b1;
                dc = slot / 2;
            end
        end
`ifdef WAVE_ARB_SPARE_EN
        if (!r && (slot % 2 == 0)) begin
            for (int j = 0; j < NUM_CH; j++)
                if (!dv && req[j] && j >= rr) begin dv = 1'b1; dc = j; end
            for (int j = 0; j < NUM_CH; j++)
                if (!dv && req[j]) begin dv = 1'b1; dc = j; end
            if (dv) rr = (dc + 1) % NUM_CH;
        end
`endif
        da     = addr[dc];
        prev_h = h_cnt[0];
        @(posedge clk);
        #1;
        hv[n] = dv;
        hc[n] = dc;
        ha[n] = da;
        if (r) begin
            slot          = 0;
            rr            = 0;
            exp_addr_last = '0;
            for (int l = 0; l < NLAT; l++) exp_data_last[l] = 8'h00;
            for (int m = n - 6; m <= n; m++) if (m >= 0) hv[m] = 1'b0;
        end else begin
            slot = (slot + 1) % 16;
        end
        if (dv) exp_addr_last = da;
        eg = dv ? NUM_CH'(1 << dc) : '0;
        for (int l = 0; l < NLAT; l++) begin
            src = n - 2 - l;
            ev  = '0;
            if (src >= 0 && hv[src]) begin
                ev               = NUM_CH'(1 << hc[src]);
                exp_data_last[l] = ha[src][7:0];
            end
            chk("h_cnt",    l + 1, 32'(h_cnt[l]),    32'(slot));
            chk("rom_rd",   l + 1, 32'(rom_rd[l]),   32'(dv));
            chk("rom_addr", l + 1, 32'(rom_addr[l]), 32'(exp_addr_last));
            chk("ch_gnt",   l + 1, 32'(gnt[l]),      32'(eg));
            chk("ch_valid", l + 1, 32'(ch_valid[l]), 32'(ev));
            chk("rd_data",  l + 1, 32'(rd_data[l]),  32'(exp_data_last[l]));
        end
        for (int k = 0; k < NUM_CH; k++) gcnt[k] += int'(gnt[0][k]);
        rd_cnt += int'(rom_rd[0]);
        for (int l = 0; l < NLAT; l++) vld_cnt += (ch_valid[l] != '0) ? 1 : 0;
        if (prev_h == 4'd15 && h_cnt[0] == 4'd0) wraps++;
        n++;
    endtask

    logic [NUM_CH-1:0] g1;
    logic [NUM_CH-1:0] g2;
    int                guard;

    initial begin
        req = '0;
        for (int k = 0; k < NUM_CH; k++) addr[k] = '0;
        for (int m = 0; m < HMAX; m++) hv[m] = 1'b0;
        clear_counts();

        // Reset state
        repeat (3) step(1'b1);

        // Single owner: channel 3, fixed address
        req     = 8'h08;
        addr[3] = 17'h00100;
        clear_counts();
        repeat (32) step(1'b0);
`ifdef WAVE_ARB_SPARE_EN
        chk("ch3_reads_per_2frames", 1, 32'(rd_cnt), 32'd18);
`else
        chk("ch3_reads_per_2frames", 1, 32'(rd_cnt), 32'd2);
`endif

        // No requesters: silent bus, counter wraps twice
        req = '0;
        clear_counts();
        repeat (32) step(1'b0);
        chk("idle_reads", 1, 32'(rd_cnt), 32'd0);
        chk("idle_wraps", 1, 32'(wraps),  32'd2);

        // Random requests and addresses
        for (int i = 0; i < 200; i++) begin
            req = NUM_CH'($urandom);
            for (int k = 0; k < NUM_CH; k++) addr[k] = ADDR_W'($urandom);
            step(1'b0);
        end

        // Fairness: channels 0, 2, 5 request continuously from a fresh reset
        req = '0;
        step(1'b1);
        req = 8'b0010_0101;
        clear_counts();
        for (int i = 0; i < 160; i++) begin
            for (int k = 0; k < NUM_CH; k++) addr[k] = ADDR_W'($urandom);
            step(1'b0);
        end
`ifdef WAVE_ARB_SPARE_EN
        chk("fair_ch0", 1, 32'(gcnt[0]), 32'd37);
        chk("fair_ch2", 1, 32'(gcnt[2]), 32'd37);
        chk("fair_ch5", 1, 32'(gcnt[5]), 32'd36);
`else
        chk("fair_ch0", 1, 32'(gcnt[0]), 32'd10);
        chk("fair_ch2", 1, 32'(gcnt[2]), 32'd10);
        chk("fair_ch5", 1, 32'(gcnt[5]), 32'd10);
`endif

        // Back-to-back: channel 0 on slots 0 and 1
        req = '0;
        step(1'b1);
        req     = 8'h01;
        addr[0] = 17'h00011;
        step(1'b0);
        g1      = gnt[0];
        addr[0] = 17'h00022;
        step(1'b0);
        g2  = gnt[0];
        req = '0;
`ifdef WAVE_ARB_SPARE_EN
        chk("b2b_gnt_first", 1, 32'(g1), 32'h01);
`else
        chk("b2b_gnt_first", 1, 32'(g1), 32'h00);
`endif
        chk("b2b_gnt_second", 1, 32'(g2), 32'h01);
        repeat (8) step(1'b0);

        // Reset one cycle after a grant: in-flight returns are dropped
        step(1'b1);
        req     = 8'h08;
        addr[3] = 17'h001AB;
        guard   = 0;
        while (gnt[0] == '0 && guard < 40) begin
            step(1'b0);
            guard++;
        end
        chk("mid_grant_seen", 1, 32'(gnt[0] != '0), 32'd1);
        req = '0;
        step(1'b1);
        clear_counts();
        repeat (8) step(1'b0);
        chk("mid_no_valid", 1, 32'(vld_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
